// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter
//   Round-robin owner selection for a single shared WIDTH-bit net. One
//   requester at a time is granted, every hand-off passes through a one-cycle
//   turnaround with no grant, and the bus output is registered from the
//   granted requester's data only, so two drivers never reach the net at once.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req        per-requester level-sensitive request
//   data_in    requester i data at [i*WIDTH +: WIDTH]
//   gnt        registered one-hot-or-zero grant
//   owner      index of current owner (meaningful while gnt or bus_valid is high)
//   bus_out    registered shared bus value, zero when no owner data
//   bus_valid  bus_out carries owner data (lags gnt by one cycle)
module shared_bus_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   data_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic [WIDTH-1:0]           bus_out,
    output logic                       bus_valid
);

    localparam int unsigned OW       = $clog2(NUM_REQ);
    localparam logic [7:0]  HOLD_MAX = 8'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t             state_q, state_d;
    logic [OW-1:0]      last_q, last_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]         hold_q, hold_d;
    logic [WIDTH-1:0]   bus_q, bus_d;
    logic               bus_valid_q, bus_valid_d;

    logic [WIDTH-1:0]   data_arr [NUM_REQ];
    logic [OW-1:0]      winner;
    logic               others;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = data_in[gi*WIDTH +: WIDTH];
    end

    // Search last+1 .. last+NUM_REQ; iterating from the far end lets the
    // nearest requesting index overwrite the others, so the previous owner
    // (offset NUM_REQ) is considered last.
    always_comb begin
        int unsigned idx;
        winner = last_q;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            idx = (32'(last_q) + k) % NUM_REQ;
            if (req[OW'(idx)]) begin
                winner = OW'(idx);
            end
        end
    end

    assign others = |(req & ~gnt_q);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        hold_d      = hold_q;
        bus_valid_d = |gnt_q;
        bus_d       = (|gnt_q) ? data_arr[owner_q] : '0;

        unique case (state_q)
            IDLE, TURN: begin
                if (|req) begin
                    state_d        = GRANT;
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                    owner_d        = winner;
                    last_d         = winner;
                    hold_d         = 8'd1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!req[owner_q] || (hold_q == HOLD_MAX && others)) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    hold_d  = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= OW'(NUM_REQ - 1);
            owner_q     <= '0;
            gnt_q       <= '0;
            hold_q      <= '0;
            bus_q       <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            hold_q      <= hold_d;
            bus_q       <= bus_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign bus_out   = bus_q;
    assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Testbench for shared_bus_arbiter: two instances (MAX_HOLD 2 and 8) share
// the same stimulus; a cycle-level reference model pushes expected outputs to
// per-instance queues that a monitor pops and compares after each edge.
module tb_shared_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [19:0] data_in;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] owner_a, owner_b;
    logic [4:0] bus_a, bus_b;
    logic       valid_a, valid_b;

    always #5 clk = ~clk;

    shared_bus_arbiter #(.NUM_REQ(4), .WIDTH(5), .MAX_HOLD(2)) dut_a (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt_a), .owner(owner_a), .bus_out(bus_a), .bus_valid(valid_a)
    );

    shared_bus_arbiter #(.NUM_REQ(4), .WIDTH(5), .MAX_HOLD(8)) dut_b (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt_b), .owner(owner_b), .bus_out(bus_b), .bus_valid(valid_b)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic [4:0] bus;
        logic       valid;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state, index 0 -> dut_a, 1 -> dut_b.
    int unsigned mh [2] = '{2, 8};
    int unsigned ms [2];            // 0 idle, 1 grant, 2 turnaround
    logic [1:0]  ml [2];
    logic [1:0]  mo [2];
    logic [3:0]  mg [2];
    int unsigned mhc [2];
    logic [4:0]  mbus [2];
    logic        mv [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ms[m] = 0; ml[m] = 2'd3; mo[m] = 2'd0; mg[m] = 4'd0;
            mhc[m] = 0; mbus[m] = 5'd0; mv[m] = 1'b0;
        end
        q_a.delete();
        q_b.delete();
    endtask

    task automatic model_step(input int m);
        int  w;
        bit  found;
        exp_t e;
        mv[m]   = (mg[m] != 4'd0);
        mbus[m] = mv[m] ? data_in[int'(mo[m])*5 +: 5] : 5'd0;
        if (ms[m] != 1) begin
            if (req != 4'd0) begin
                found = 1'b0;
                w = 0;
                for (int k = 1; k <= 4; k++) begin
                    int idx;
                    idx = (int'(ml[m]) + k) % 4;
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        w = idx;
                    end
                end
                ms[m] = 1; mg[m] = 4'd1 << w; mo[m] = 2'(w); ml[m] = 2'(w); mhc[m] = 1;
            end else begin
                ms[m] = 0; mg[m] = 4'd0; mhc[m] = 0;
            end
        end else begin
            if (!req[mo[m]] || (mhc[m] == mh[m] && (req & ~mg[m]) != 4'd0)) begin
                ms[m] = 2; mg[m] = 4'd0; mhc[m] = 0;
            end else if (mhc[m] < mh[m]) begin
                mhc[m]++;
            end
        end
        e.gnt = mg[m]; e.owner = mo[m]; e.bus = mbus[m]; e.valid = mv[m];
        if (m == 0) q_a.push_back(e); else q_b.push_back(e);
    endtask

    // Called at a negedge: drive inputs, predict the next edge, wait a cycle.
    task automatic step(input logic [3:0] r, input logic [19:0] d);
        req     = r;
        data_in = d;
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt_a"}, gnt_a, 0);
        check({tag, "_bus_a"}, bus_a, 0);
        check({tag, "_valid_a"}, valid_a, 0);
        check({tag, "_gnt_b"}, gnt_b, 0);
        check({tag, "_bus_b"}, bus_b, 0);
        check({tag, "_valid_b"}, valid_b, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic compare(input string nm, input exp_t e, input logic [3:0] g,
                           input logic [1:0] o, input logic [4:0] b, input logic v);
        check({"gnt_", nm}, g, e.gnt);
        check({"bus_", nm}, b, e.bus);
        check({"valid_", nm}, v, e.valid);
        if (e.gnt != 4'd0 || e.valid) check({"owner_", nm}, o, e.owner);
    endtask

    logic [1:0] order_q[$];
    bit         rr_track = 1'b0;
    logic [3:0] prev_gnt_a = 4'd0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (q_a.size() > 0) compare("a", q_a.pop_front(), gnt_a, owner_a, bus_a, valid_a);
            if (q_b.size() > 0) compare("b", q_b.pop_front(), gnt_b, owner_b, bus_b, valid_b);
            check("onehot_a", 32'($countones(gnt_a) <= 1), 1);
            check("onehot_b", 32'($countones(gnt_b) <= 1), 1);
            if (rr_track && gnt_a != 4'd0 && prev_gnt_a == 4'd0) order_q.push_back(owner_a);
        end
        prev_gnt_a <= gnt_a;
    end

    initial begin
        logic [19:0] d;
        logic [1:0]  rr_exp [5];
        rst = 1'b1;
        req = 4'd0;
        data_in = 20'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        // Idle with no requests
        repeat (3) step(4'd0, 20'd0);
        check("idle_gnt", gnt_a, 0);
        check("idle_valid", valid_b, 0);

        // Single request from requester 2
        d = 20'd0;
        d[14:10] = 5'h1A;
        step(4'b0100, d);
        check("single_gnt", gnt_b, 4'b0100);
        check("single_nv", valid_b, 0);
        step(4'b0100, d);
        check("single_bus", bus_b, 5'h1A);
        check("single_valid", valid_b, 1);
        step(4'b0000, d);
        check("rel_gnt", gnt_b, 0);
        check("rel_valid", valid_b, 1);
        step(4'b0000, d);
        check("rel_valid2", valid_b, 0);
        check("rel_bus", bus_b, 0);

        // Round robin, all requesting
        do_reset();
        order_q.delete();
        rr_track = 1'b1;
        for (int i = 0; i < 16; i++) step(4'hF, 20'($urandom));
        rr_track = 1'b0;
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        check("rr_count", 32'(order_q.size() >= 5), 1);
        for (int i = 0; i < 5; i++)
            check("rr_order", (i < order_q.size()) ? 32'(order_q[i]) : 32'd99, 32'(rr_exp[i]));

        // Saturation: lone requester keeps grant, then a waiter forces hand-off
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b0010, 20'($urandom));
            check("sat_gnt", gnt_b, 4'b0010);
        end
        step(4'b1010, 20'($urandom));
        check("sat_drop", gnt_b, 0);
        step(4'b1010, 20'($urandom));
        check("sat_next", gnt_b, 4'b1000);

        // Random contention traffic
        for (int i = 0; i < 60; i++) begin
            d = 20'($urandom);
            d[4:0] = 5'h1F;
            d[9:5] = 5'h00;
            step(4'($urandom_range(0, 15)), d);
        end
        repeat (3) step(4'd0, 20'd0);

        // Asynchronous reset in the middle of a grant
        do_reset();
        d = 20'($urandom);
        d[14:10] = 5'h0B;
        repeat (3) step(4'b0100, d);
        check("pre_gnt", gnt_b, 4'b0100);
        check("pre_bus", bus_b, 5'h0B);
        #2 rst = 1'b1;
        #1 check_zero("async");
        model_reset();
        #1 rst = 1'b0;
        step(4'b0110, d);
        check("async_first", gnt_a, 4'b0010);
        check("async_first_b", gnt_b, 4'b0010);
        repeat (4) step(4'b0110, d);
        repeat (2) step(4'd0, d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
